uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmit byte path (Tx_start/data into the UART TX buffer top) among up to four byte producers, e.g. multiple VLIW lanes, a debug dumper and a status reporter. It accepts bytes over per-requester valid/ready handshakes. It supports multi-byte message locking so messages from different requesters never interleave. It paces issue to the downstream write state machine's acceptance rate.

---
 rtl/uart_tx_arb.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX byte path among NREQ producers,
// with multi-byte message locking, issue pacing and a stalled-lock timeout.
//   state   | meaning
//   ST_IDLE | arbitrating; a transfer may happen this cycle
//   ST_GAP  | pacing after an issue; gap down-counter runs to zero
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int GAP     = 3,
  parameter int LOCK_TO = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req_valid,
  input  logic [8*NREQ-1:0]   i_req_data,
  input  logic [NREQ-1:0]     i_req_last,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic                i_tx_hold,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  output logic [1:0]          o_grant_id,
  output logic                o_locked,
  output logic                o_lock_timeout
);

  localparam int GAP_W  = $clog2(GAP);
  localparam int IDLE_W = $clog2(LOCK_TO + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [0:0]        r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;
  logic              r_locked;
  logic              r_lock_timeout;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic [1:0]        r_grant_id;

  logic              w_scan_hit;
  logic [1:0]        w_scan_id;
  logic              w_own_valid;
  logic              w_win_hit;
  logic [1:0]        w_win_id;
  logic [7:0]        w_win_data;
  logic              w_win_last;
  logic              w_xfer;
  logic              w_idle_tick;
  logic              w_lock_expire;

  // First valid requester after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_id  = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_scan_hit && i_req_valid[i] && (i == (int'(r_ptr) + k) % NREQ)) begin
          w_scan_hit = 1'b1;
          w_scan_id  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(r_owner)) begin
        w_own_valid = i_req_valid[i];
      end
    end
  end

  assign w_win_hit = r_locked ? w_own_valid : w_scan_hit;
  assign w_win_id  = r_locked ? r_owner     : w_scan_id;
  assign w_xfer    = !i_rst && (r_state == ST_IDLE) && !i_tx_hold && w_win_hit;

  always_comb begin
    w_win_data  = 8'h00;
    w_win_last  = 1'b0;
    o_req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(w_win_id)) begin
        w_win_data     = i_req_data[8*i +: 8];
        w_win_last     = i_req_last[i];
        o_req_ready[i] = w_xfer;
      end
    end
  end

  // A stalled owner only burns idle time while the path is free to take its byte.
  assign w_idle_tick   = r_locked && (r_state == ST_IDLE) && !i_tx_hold && !w_xfer;
  assign w_lock_expire = w_idle_tick && (r_idle_cnt == IDLE_W'(LOCK_TO - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_ptr          <= 2'(NREQ - 1);
      r_owner        <= 2'd0;
      r_locked       <= 1'b0;
      r_lock_timeout <= 1'b0;
      r_gap_cnt      <= '0;
      r_idle_cnt     <= '0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= 8'h00;
      r_grant_id     <= 2'd0;
    end else begin
      r_tx_start <= w_xfer;
      if (w_xfer) begin
        r_tx_data  <= w_win_data;
        r_grant_id <= w_win_id;
        r_ptr      <= w_win_id;
        r_state    <= ST_GAP;
        r_gap_cnt  <= GAP_W'(GAP - 2);
        r_idle_cnt <= '0;
        if (w_win_last) begin
          r_locked <= 1'b0;
        end else begin
          r_locked <= 1'b1;
          r_owner  <= w_win_id;
        end
      end else begin
        if (r_state == ST_GAP) begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        if (w_lock_expire) begin
          r_locked       <= 1'b0;
          r_lock_timeout <= 1'b1;
          r_ptr          <= r_owner;
          r_idle_cnt     <= '0;
        end else if (w_idle_tick) begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign o_tx_start     = r_tx_start;
  assign o_tx_data      = r_tx_data;
  assign o_grant_id     = r_grant_id;
  assign o_locked       = r_locked;
  assign o_lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_uart_tx_arb;

  localparam int NREQ    = 4;
  localparam int GAP     = 3;
  localparam int LOCK_TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_hold;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        locked;
  logic        lock_timeout;

  uart_tx_arb #(.NREQ(NREQ), .GAP(GAP), .LOCK_TO(LOCK_TO)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .i_tx_hold      (tx_hold),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .o_grant_id     (grant_id),
    .o_locked       (locked),
    .o_lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester side: per-requester byte queues, optionally muted.
  logic [7:0] q_data[NREQ][$];
  bit         q_last[NREQ][$];
  logic [3:0] mute;

  // Reference model state; the gap is tracked as an earliest-issue cycle.
  longint cyc;
  longint m_ok;
  int     m_ptr, m_owner, m_idle, m_data, m_gid;
  bit     m_locked, m_to, m_start;

  int     mon_gid[$];
  int     mon_data[$];
  longint mon_cyc[$];

  task automatic model_reset();
    m_ptr = NREQ - 1; m_owner = 0; m_idle = 0; m_data = 0; m_gid = 0;
    m_locked = 0; m_to = 0; m_start = 0;
    m_ok = cyc + 1;
  endtask

  task automatic push_msg(input int r, input int len, input int base);
    for (int j = 0; j < len; j++) begin
      q_data[r].push_back(8'(base + j));
      q_last[r].push_back(j == len - 1);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    mute = 4'b0;
    mon_gid.delete(); mon_data.delete(); mon_cyc.delete();
  endtask

  task automatic step(input bit r, input bit h);
    int         w, c;
    bit         fire, wl;
    logic [7:0] wd;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst = r;
    tx_hold = h;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q_data[i].size() > 0) && !mute[i];
      req_data[8*i +: 8] = req_valid[i] ? q_data[i][0] : 8'h00;
      req_last[i] = req_valid[i] ? q_last[i][0] : 1'b0;
    end
    #1;
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data", 32'(tx_data), m_data);
    chk("grant_id", 32'(grant_id), m_gid);
    chk("locked", 32'(locked), 32'(m_locked));
    chk("lock_timeout", 32'(lock_timeout), 32'(m_to));
    if (tx_start) begin
      mon_gid.push_back(int'(grant_id));
      mon_data.push_back(int'(tx_data));
      mon_cyc.push_back(cyc);
    end
    w = -1;
    if (m_locked) begin
      for (int i = 0; i < NREQ; i++) if (i == m_owner && req_valid[i]) w = i;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        for (int i = 0; i < NREQ; i++) if (w < 0 && i == c && req_valid[i]) w = i;
      end
    end
    fire = !r && !h && (cyc >= m_ok) && (w >= 0);
    wd = 8'h00; wl = 0;
    for (int i = 0; i < NREQ; i++) begin
      exp_rdy[i] = fire && (i == w);
      if (i == w) begin
        wd = req_data[8*i +: 8];
        wl = req_last[i];
      end
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    if (r) begin
      model_reset();
    end else begin
      m_start = fire;
      if (fire) begin
        m_data = int'(wd); m_gid = w; m_ptr = w;
        m_ok = cyc + GAP;
        m_idle = 0;
        if (wl) m_locked = 0;
        else begin
          m_locked = 1;
          m_owner = w;
        end
      end else if (m_locked && cyc >= m_ok && !h) begin
        m_idle++;
        if (m_idle >= LOCK_TO) begin
          m_locked = 0; m_to = 1; m_ptr = m_owner; m_idle = 0;
        end
      end
    end
    cyc++;
  endtask

  longint t0;
  int     exp_gid[5] = '{1, 1, 1, 3, 0};
  int     exp_dat[5] = '{'h10, 'h11, 'h12, 'hD0, 'hA0};

  initial begin
    rst = 1'b1; tx_hold = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    cyc = 0;
    clear_all();
    repeat (2) @(posedge clk);
    model_reset();
    m_ok = 0;

    // single requester
    step(1, 0); clear_all();
    push_msg(2, 1, 'h41);
    t0 = cyc;
    repeat (5) step(0, 0);
    chk("s1_count", 32'(mon_gid.size()), 1);
    if (mon_gid.size() > 0) begin
      chk("s1_gid", 32'(mon_gid[0]), 2);
      chk("s1_data", 32'(mon_data[0]), 'h41);
      chk("s1_latency", 32'(mon_cyc[0] - t0), 1);
    end

    // continuous demand from all four
    step(1, 0); clear_all();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) if (q_data[i].size() == 0) push_msg(i, 1, $urandom_range(0, 255));
      step(0, 0);
    end
    chk("s2_count", 32'(mon_gid.size() >= 9), 1);
    if (mon_gid.size() > 0) chk("s2_first", 32'(mon_gid[0]), 0);
    for (int j = 1; j < mon_gid.size(); j++) begin
      chk("s2_order", 32'(mon_gid[j]), 32'((mon_gid[j-1] + 1) % NREQ));
      chk("s2_spacing", 32'(mon_cyc[j] - mon_cyc[j-1]), GAP);
    end

    // locked message is contiguous, then round-robin resumes
    step(1, 0); clear_all();
    q_data[1].push_back(8'h10); q_last[1].push_back(0);
    step(0, 0);
    q_data[1].push_back(8'h11); q_last[1].push_back(0);
    q_data[1].push_back(8'h12); q_last[1].push_back(1);
    push_msg(0, 1, 'hA0);
    push_msg(3, 1, 'hD0);
    repeat (20) step(0, 0);
    chk("s3_count", 32'(mon_gid.size()), 5);
    for (int j = 0; j < 5 && j < mon_gid.size(); j++) begin
      chk("s3_gid", 32'(mon_gid[j]), 32'(exp_gid[j]));
      chk("s3_data", 32'(mon_data[j]), 32'(exp_dat[j]));
    end

    // lock timeout
    step(1, 0); clear_all();
    q_data[0].push_back(8'h77); q_last[0].push_back(0);
    step(0, 0);
    push_msg(1, 1, 'h55);
    repeat (20) step(0, 0);
    chk("s4_count", 32'(mon_gid.size()), 2);
    if (mon_gid.size() == 2) begin
      chk("s4_gid", 32'(mon_gid[1]), 1);
      chk("s4_spacing", 32'(mon_cyc[1] - mon_cyc[0]), 11);
    end
    chk("s4_sticky", 32'(lock_timeout), 1);

    // tx_hold
    step(1, 0); clear_all();
    push_msg(0, 1, 'h33);
    repeat (10) step(0, 1);
    chk("s5_held", 32'(mon_gid.size()), 0);
    t0 = cyc;
    repeat (2) step(0, 0);
    chk("s5_count", 32'(mon_gid.size()), 1);
    if (mon_gid.size() > 0) chk("s5_latency", 32'(mon_cyc[0] - t0), 1);

    // reset mid-lock during the gap
    step(1, 0); clear_all();
    q_data[2].push_back(8'h21); q_last[2].push_back(0);
    q_data[2].push_back(8'h22); q_last[2].push_back(1);
    step(0, 0);
    push_msg(0, 1, 'h05);
    step(1, 0);
    mon_gid.delete(); mon_data.delete(); mon_cyc.delete();
    step(0, 0);
    chk("s6_locked", 32'(locked), 0);
    chk("s6_start", 32'(tx_start), 0);
    repeat (8) step(0, 0);
    if (mon_gid.size() > 0) chk("s6_first", 32'(mon_gid[0]), 0);
    else chk("s6_count", 0, 1);

    // randomized traffic
    step(1, 0); clear_all();
    for (int n = 0; n < 3000; n++) begin
      if (n % 16 == 0) mute = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      for (int i = 0; i < NREQ; i++)
        if (q_data[i].size() == 0 && $urandom_range(0, 3) == 0)
          push_msg(i, $urandom_range(1, 3), $urandom_range(0, 255));
      step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
